// File: rtl/via_access_sequencer_pkg.sv
// Shared constants for the VIA access sequencer: FSM encodings, 6522 register
// selects and the power-on initialisation table.
package via_seq_pkg;

    localparam logic [1:0] S_RESET = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;

    localparam logic [3:0] RS_ORB  = 4'h0;
    localparam logic [3:0] RS_ORA  = 4'h1;
    localparam logic [3:0] RS_DDRB = 4'h2;
    localparam logic [3:0] RS_DDRA = 4'h3;
    localparam logic [3:0] RS_T1CL = 4'h4;
    localparam logic [3:0] RS_T1CH = 4'h5;
    localparam logic [3:0] RS_ACR  = 4'hB;
    localparam logic [3:0] RS_PCR  = 4'hC;
    localparam logic [3:0] RS_IFR  = 4'hD;
    localparam logic [3:0] RS_IER  = 4'hE;

    localparam int INIT_COUNT = 6;

    typedef struct packed {
        logic [3:0] rs;
        logic [7:0] data;
    } init_entry_t;

    // Writes replayed after every reset; IER is cleared before CA1 is enabled.
    function automatic init_entry_t init_entry(input logic [2:0] idx);
        case (idx)
            3'd0:    init_entry = '{rs: RS_DDRB, data: 8'h0F};
            3'd1:    init_entry = '{rs: RS_DDRA, data: 8'h7F};
            3'd2:    init_entry = '{rs: RS_PCR,  data: 8'h04};
            3'd3:    init_entry = '{rs: RS_ACR,  data: 8'h40};
            3'd4:    init_entry = '{rs: RS_IER,  data: 8'h7F};
            3'd5:    init_entry = '{rs: RS_IER,  data: 8'h82};
            default: init_entry = '{rs: RS_ORB,  data: 8'h00};
        endcase
    endfunction

endpackage

// File: rtl/via_access_sequencer_if.sv
// Bus bundle around the VIA access sequencer: CPU side, secondary master side
// and the VIA register port. The sequencer uses the master modport.
interface via_access_sequencer_if;
    import via_seq_pkg::*;

    logic       CPU_CS;
    logic       CPU_RnW;
    logic [3:0] CPU_RS;
    logic [7:0] CPU_WDATA;
    logic [7:0] CPU_RDATA;
    logic       CPU_RDY;

    logic       M_REQ;
    logic       M_RnW;
    logic [3:0] M_RS;
    logic [7:0] M_WDATA;
    logic       M_ACK;
    logic [7:0] M_RDATA;

    logic       VIA_nRESET;
    logic       VIA_CS;
    logic       VIA_RnW;
    logic [3:0] VIA_RS;
    logic [7:0] VIA_WDATA;
    logic [7:0] VIA_RDATA;

    logic       BUSY_INIT;

    modport master (
        input  CPU_CS, CPU_RnW, CPU_RS, CPU_WDATA,
        input  M_REQ, M_RnW, M_RS, M_WDATA,
        input  VIA_RDATA,
        output CPU_RDATA, CPU_RDY, M_ACK, M_RDATA,
        output VIA_nRESET, VIA_CS, VIA_RnW, VIA_RS, VIA_WDATA,
        output BUSY_INIT
    );

    modport slave (
        output CPU_CS, CPU_RnW, CPU_RS, CPU_WDATA,
        output M_REQ, M_RnW, M_RS, M_WDATA,
        output VIA_RDATA,
        input  CPU_RDATA, CPU_RDY, M_ACK, M_RDATA,
        input  VIA_nRESET, VIA_CS, VIA_RnW, VIA_RS, VIA_WDATA,
        input  BUSY_INIT
    );

endinterface

// File: rtl/via_access_sequencer_arbiter.sv
// Per-cycle slot arbiter: CPU has priority, the secondary master is forced in
// once it has waited MAX_WAIT (1..15) cycles.
module via_slot_arbiter
    import via_seq_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic CLK,
    input  logic RESET,
    input  logic run,
    input  logic cpu_cs,
    input  logic m_req,
    output logic grant_cpu,
    output logic grant_m,
    output logic forced
);

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    always_comb begin
        forced    = run && m_req && (wait_cnt == WAIT_MAX);
        grant_cpu = run && !forced && cpu_cs;
        grant_m   = run && (forced || (!cpu_cs && m_req));
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            wait_cnt <= '0;
        end else if (!run || !m_req || grant_m) begin
            wait_cnt <= '0;
        end else if (grant_cpu && (wait_cnt != WAIT_MAX)) begin
            wait_cnt <= wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/via_access_sequencer.sv
// Owns the 6522 VIA register port: replays the init table after reset, then
// shares the port between the 6502 and a secondary bus master.
module via_access_sequencer
    import via_seq_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input logic                   CLK,
    input logic                   RESET,
    via_access_sequencer_if.master bus
);

    localparam logic [2:0] IDX_LAST = 3'(INIT_COUNT - 1);

    logic [1:0]  state;
    logic [2:0]  idx;
    logic        m_ack_q;
    logic [7:0]  m_rdata_q;
    logic        grant_cpu;
    logic        grant_m;
    logic        forced;
    init_entry_t init_cur;

    via_slot_arbiter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_arbiter (
        .CLK       (CLK),
        .RESET     (RESET),
        .run       (state == S_RUN),
        .cpu_cs    (bus.CPU_CS),
        .m_req     (bus.M_REQ),
        .grant_cpu (grant_cpu),
        .grant_m   (grant_m),
        .forced    (forced)
    );

    // Reset wins over a master access closing on the same edge: no ACK.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= S_RESET;
            idx       <= '0;
            m_ack_q   <= 1'b0;
            m_rdata_q <= '0;
        end else begin
            m_ack_q <= grant_m;
            if (grant_m && bus.M_RnW) begin
                m_rdata_q <= bus.VIA_RDATA;
            end
            case (state)
                S_RESET: state <= S_INIT;
                S_INIT: begin
                    if (idx == IDX_LAST) begin
                        state <= S_RUN;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                S_RUN:   state <= S_RUN;
                default: state <= S_RESET;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        init_cur      = init_entry(idx);
        bus.VIA_CS    = 1'b0;
        bus.VIA_RnW   = bus.CPU_RnW;
        bus.VIA_RS    = bus.CPU_RS;
        bus.VIA_WDATA = bus.CPU_WDATA;
        case (state)
            S_INIT: begin
                bus.VIA_CS    = 1'b1;
                bus.VIA_RnW   = 1'b0;
                bus.VIA_RS    = init_cur.rs;
                bus.VIA_WDATA = init_cur.data;
            end
            S_RUN: begin
                if (grant_m) begin
                    bus.VIA_CS    = 1'b1;
                    bus.VIA_RnW   = bus.M_RnW;
                    bus.VIA_RS    = bus.M_RS;
                    bus.VIA_WDATA = bus.M_WDATA;
                end else if (grant_cpu) begin
                    bus.VIA_CS = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // The VIA sees one released cycle in S_RESET before the first init write.
    assign bus.VIA_nRESET = (state != S_RESET) || !RESET;
    assign bus.CPU_RDY    = (state == S_RUN) && !forced;
    assign bus.CPU_RDATA  = bus.VIA_RDATA;
    assign bus.BUSY_INIT  = (state != S_RUN);
    assign bus.M_ACK      = m_ack_q;
    assign bus.M_RDATA    = m_rdata_q;

endmodule

// File: tb/tb_via_access_sequencer.sv
// Scoreboard bench for via_access_sequencer: stimulus queues the expected VIA
// accesses and master ACKs, a negedge monitor pops and compares them.
module tb_via_access_sequencer;

    localparam int MAX_WAIT = 4;
    localparam logic [11:0] INIT_TAB [6] = '{12'h20F, 12'h37F, 12'hC04,
                                             12'hB40, 12'hE7F, 12'hE82};

    typedef struct {
        int         cyc;
        logic       rnw;
        logic [3:0] rs;
        logic [7:0] wd;
        logic       rdy;
        logic       busy;
    } via_exp_t;

    typedef struct {
        int         cyc;
        logic [7:0] rd;
    } ack_exp_t;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    via_exp_t via_q[$];
    ack_exp_t ack_q[$];

    via_access_sequencer_if bus();

    via_access_sequencer #(
        .MAX_WAIT (MAX_WAIT)
    ) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic cpu(input logic cs, input logic rnw, input logic [3:0] rs, input logic [7:0] wd);
        bus.CPU_CS    = cs;
        bus.CPU_RnW   = rnw;
        bus.CPU_RS    = rs;
        bus.CPU_WDATA = wd;
    endtask

    task automatic mst(input logic req, input logic rnw, input logic [3:0] rs, input logic [7:0] wd);
        bus.M_REQ   = req;
        bus.M_RnW   = rnw;
        bus.M_RS    = rs;
        bus.M_WDATA = wd;
    endtask

    task automatic push_via(input int c, input logic rnw, input logic [3:0] rs,
                            input logic [7:0] wd, input logic rdy, input logic busy);
        via_exp_t e;
        e = '{cyc: c, rnw: rnw, rs: rs, wd: wd, rdy: rdy, busy: busy};
        via_q.push_back(e);
    endtask

    task automatic push_ack(input int c, input logic [7:0] rd);
        ack_exp_t e;
        e = '{cyc: c, rd: rd};
        ack_q.push_back(e);
    endtask

    task automatic push_init(input int c0);
        logic [11:0] t;
        for (int i = 0; i < 6; i++) begin
            t = INIT_TAB[i];
            push_via(c0 + i, 1'b0, t[11:8], t[7:0], 1'b0, 1'b1);
        end
    endtask

    // Monitor: every VIA slot and every master ACK must match the next queued entry.
    always @(negedge CLK) begin
        via_exp_t ve;
        ack_exp_t ae;
        if (bus.VIA_CS === 1'b1) begin
            if (via_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL via_unexpected: access rs=%0h wd=%0h, none expected (cycle %0d)",
                         bus.VIA_RS, bus.VIA_WDATA, cyc);
            end else begin
                ve = via_q.pop_front();
                check("via_cycle", cyc, ve.cyc);
                check("via_rnw", {31'd0, bus.VIA_RnW}, {31'd0, ve.rnw});
                check("via_rs", {28'd0, bus.VIA_RS}, {28'd0, ve.rs});
                check("via_wdata", {24'd0, bus.VIA_WDATA}, {24'd0, ve.wd});
                check("cpu_rdy", {31'd0, bus.CPU_RDY}, {31'd0, ve.rdy});
                check("busy_init", {31'd0, bus.BUSY_INIT}, {31'd0, ve.busy});
            end
        end
        if (bus.M_ACK === 1'b1) begin
            if (ack_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL ack_unexpected: M_ACK with rdata=%0h, none expected (cycle %0d)",
                         bus.M_RDATA, cyc);
            end else begin
                ae = ack_q.pop_front();
                check("ack_cycle", cyc, ae.cyc);
                check("m_rdata", {24'd0, bus.M_RDATA}, {24'd0, ae.rd});
            end
        end
    end

    initial begin
        int b;
        cpu(1'b0, 1'b1, 4'h0, 8'h00);
        mst(1'b0, 1'b1, 4'h0, 8'h00);
        bus.VIA_RDATA = 8'h00;
        RESET = 1'b1;

        // Reset held for three sampled edges
        step();
        step();
        @(negedge CLK);
        check("rst_via_nreset", {31'd0, bus.VIA_nRESET}, 32'd0);
        check("rst_via_cs", {31'd0, bus.VIA_CS}, 32'd0);
        check("rst_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd0);
        check("rst_m_ack", {31'd0, bus.M_ACK}, 32'd0);
        check("rst_m_rdata", {24'd0, bus.M_RDATA}, 32'd0);
        check("rst_busy_init", {31'd0, bus.BUSY_INIT}, 32'd1);
        step();
        RESET = 1'b0;
        b = cyc;
        push_init(b + 1);
        @(negedge CLK);
        check("rel_via_nreset", {31'd0, bus.VIA_nRESET}, 32'd1);
        check("rel_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd0);
        check("rel_busy_init", {31'd0, bus.BUSY_INIT}, 32'd1);
        while (cyc < b + 7) step();

        // CPU priority: continuous CPU reads, master write forced in on the 5th cycle
        b = cyc;
        cpu(1'b1, 1'b1, 4'h1, 8'h00);
        mst(1'b1, 1'b0, 4'h0, 8'h55);
        bus.VIA_RDATA = 8'h3C;
        for (int i = 0; i < MAX_WAIT; i++) push_via(b + i, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0);
        push_via(b + MAX_WAIT, 1'b0, 4'h0, 8'h55, 1'b0, 1'b0);
        push_ack(b + MAX_WAIT + 1, 8'h00);
        push_via(b + MAX_WAIT + 1, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0);
        push_via(b + MAX_WAIT + 2, 1'b1, 4'h1, 8'h00, 1'b1, 1'b0);
        @(negedge CLK);
        check("run_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd1);
        check("run_busy_init", {31'd0, bus.BUSY_INIT}, 32'd0);
        check("cpu_rdata", {24'd0, bus.CPU_RDATA}, 32'h3C);
        while (cyc < b + MAX_WAIT + 1) step();
        mst(1'b0, 1'b0, 4'h0, 8'h00);
        step();
        step();
        cpu(1'b0, 1'b1, 4'h0, 8'h00);

        // Idle master read, then a replacement write presented in the ACK cycle
        b = cyc;
        mst(1'b1, 1'b1, 4'hD, 8'h11);
        bus.VIA_RDATA = 8'hA2;
        push_via(b, 1'b1, 4'hD, 8'h11, 1'b1, 1'b0);
        push_ack(b + 1, 8'hA2);
        @(negedge CLK);
        check("idle_cpu_rdata", {24'd0, bus.CPU_RDATA}, 32'hA2);
        step();
        mst(1'b1, 1'b0, 4'h0, 8'h66);
        bus.VIA_RDATA = 8'h00;
        push_via(b + 1, 1'b0, 4'h0, 8'h66, 1'b1, 1'b0);
        push_ack(b + 2, 8'hA2);
        step();
        mst(1'b0, 1'b0, 4'h0, 8'h00);
        step();

        // Abandoned request under CPU traffic, then a fresh one waits the full budget
        b = cyc;
        cpu(1'b1, 1'b1, 4'h4, 8'h00);
        mst(1'b1, 1'b0, 4'h5, 8'h99);
        for (int i = 0; i < 4; i++) push_via(b + i, 1'b1, 4'h4, 8'h00, 1'b1, 1'b0);
        step();
        step();
        mst(1'b0, 1'b0, 4'h5, 8'h99);
        step();
        step();
        mst(1'b1, 1'b0, 4'h5, 8'h99);
        for (int i = 0; i < MAX_WAIT; i++) push_via(b + 4 + i, 1'b1, 4'h4, 8'h00, 1'b1, 1'b0);
        push_via(b + 4 + MAX_WAIT, 1'b0, 4'h5, 8'h99, 1'b0, 1'b0);
        push_ack(b + 5 + MAX_WAIT, 8'hA2);
        push_via(b + 5 + MAX_WAIT, 1'b1, 4'h4, 8'h00, 1'b1, 1'b0);
        while (cyc < b + 5 + MAX_WAIT) step();
        mst(1'b0, 1'b0, 4'h0, 8'h00);
        step();
        cpu(1'b0, 1'b1, 4'h0, 8'h00);
        step();

        // Reset during a forced master cycle; master stays requesting through init
        b = cyc;
        cpu(1'b1, 1'b1, 4'h2, 8'h00);
        mst(1'b1, 1'b0, 4'h3, 8'h77);
        for (int i = 0; i < MAX_WAIT; i++) push_via(b + i, 1'b1, 4'h2, 8'h00, 1'b1, 1'b0);
        push_via(b + MAX_WAIT, 1'b0, 4'h3, 8'h77, 1'b0, 1'b0);
        while (cyc < b + MAX_WAIT) step();
        RESET = 1'b1;
        step();
        @(negedge CLK);
        check("mid_rst_via_nreset", {31'd0, bus.VIA_nRESET}, 32'd0);
        check("mid_rst_cpu_rdy", {31'd0, bus.CPU_RDY}, 32'd0);
        check("mid_rst_busy_init", {31'd0, bus.BUSY_INIT}, 32'd1);
        check("mid_rst_m_ack", {31'd0, bus.M_ACK}, 32'd0);
        step();
        RESET = 1'b0;
        b = cyc;
        push_init(b + 1);
        push_via(b + 7, 1'b1, 4'h2, 8'h00, 1'b1, 1'b0);
        push_via(b + 8, 1'b0, 4'h3, 8'h77, 1'b1, 1'b0);
        push_ack(b + 9, 8'h00);
        while (cyc < b + 8) step();
        cpu(1'b0, 1'b1, 4'h0, 8'h00);
        step();
        mst(1'b0, 1'b0, 4'h0, 8'h00);
        repeat (3) step();

        check("via_queue_empty", via_q.size(), 32'd0);
        check("ack_queue_empty", ack_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
